// File: rtl/pulse_to_level_moore.sv
// pulse_to_level_moore
// Turns single-cycle tick events into clean level windows: WIDTH cycles high,
// then at least GAP cycles low. One tick arriving while busy is held in a
// one-deep pending slot; any further tick is dropped and reported on miss.
// With RETRIG=1 a tick during the high window restarts the window instead of
// being buffered.
module pulse_to_level_moore #(
   parameter int WIDTH  = 4,
   parameter int GAP    = 2,
   parameter int RETRIG = 0,
   parameter int CW     = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   output logic level,
   output logic busy,
   output logic miss
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   localparam logic [CW-1:0] WLOAD = CW'(WIDTH - 1);
   localparam logic [CW-1:0] GLOAD = CW'(GAP - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          pend;

   // State machine; level/busy are registered from the next state so they
   // stay pure functions of the stored state, and miss marks a dropped tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         pend  <= 1'b0;
         level <= 1'b0;
         busy  <= 1'b0;
         miss  <= 1'b0;
      end else begin
         miss <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tick) begin
                  state <= S_HIGH;
                  cnt   <= WLOAD;
                  level <= 1'b1;
                  busy  <= 1'b1;
               end else begin
                  level <= 1'b0;
                  busy  <= pend;
               end
            end

            S_HIGH: begin
               busy <= 1'b1;
               if ((RETRIG != 0) && tick) begin
                  // Reload takes priority over the window expiring.
                  cnt   <= WLOAD;
                  level <= 1'b1;
               end else begin
                  if (cnt == '0) begin
                     state <= S_GAP;
                     cnt   <= GLOAD;
                     level <= 1'b0;
                  end else begin
                     cnt   <= cnt - 1'b1;
                     level <= 1'b1;
                  end
                  if (tick) begin
                     if (!pend) pend <= 1'b1;
                     else       miss <= 1'b1;
                  end
               end
            end

            S_GAP: begin
               if (cnt != '0) begin
                  cnt   <= cnt - 1'b1;
                  level <= 1'b0;
                  busy  <= 1'b1;
                  if (tick) begin
                     if (!pend) pend <= 1'b1;
                     else       miss <= 1'b1;
                  end
               end else if (pend || tick) begin
                  // Consume one event; a second simultaneous one stays pending.
                  state <= S_HIGH;
                  cnt   <= WLOAD;
                  pend  <= pend & tick;
                  level <= 1'b1;
                  busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  level <= 1'b0;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= S_IDLE;
               cnt   <= '0;
               pend  <= 1'b0;
               level <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_to_level_moore.sv
// tb_pulse_to_level_moore
// Drives two instances (RETRIG=0 and RETRIG=1) from a shared tick stream and
// compares them every cycle with a time-based window schedule model, then
// applies a randomized tick stream with occasional asynchronous resets.
module tb_pulse_to_level_moore;

   localparam int W = 4;
   localparam int G = 2;

   logic clk = 1'b0;
   logic reset;
   logic tick;
   logic level0, busy0, miss0;
   logic level1, busy1, miss1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Model: absolute cycle of the last high cycle and last busy (gap) cycle
   // of the current window, plus the pending flag and an expected miss.
   int we [2];
   int bu [2];
   bit pd [2];
   bit me [2];

   logic h_lvl  [2][0:63];
   logic h_busy [2][0:63];
   logic h_miss [2][0:63];

   pulse_to_level_moore #(.WIDTH(W), .GAP(G), .RETRIG(0), .CW(8)) dut0 (
      .clk(clk), .reset(reset), .tick(tick),
      .level(level0), .busy(busy0), .miss(miss0)
   );

   pulse_to_level_moore #(.WIDTH(W), .GAP(G), .RETRIG(1), .CW(8)) dut1 (
      .clk(clk), .reset(reset), .tick(tick),
      .level(level1), .busy(busy1), .miss(miss1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int r = 0; r < 2; r++) begin
         we[r] = -100;
         bu[r] = -100;
         pd[r] = 1'b0;
         me[r] = 1'b0;
      end
   endfunction

   function automatic void model_buffer(input int r);
      if (!pd[r]) pd[r] = 1'b1;
      else        me[r] = 1'b1;
   endfunction

   function automatic void model_start(input int r, input int t);
      we[r] = t + W;
      bu[r] = t + W + G;
   endfunction

   // Applies the tick seen at the end of cycle t to instance r.
   function automatic void model_step(input int r, input bit tk, input int t);
      me[r] = 1'b0;
      if (t <= we[r]) begin
         if (tk) begin
            if (r == 1) model_start(r, t);
            else        model_buffer(r);
         end
      end else if (t <= bu[r]) begin
         if (t == bu[r]) begin
            if (pd[r] || tk) begin
               model_start(r, t);
               pd[r] = pd[r] & tk;
            end
         end else if (tk) begin
            model_buffer(r);
         end
      end else if (tk) begin
         model_start(r, t);
      end
   endfunction

   task automatic check_outputs();
      logic [2:0] got [2];
      got[0] = {level0, busy0, miss0};
      got[1] = {level1, busy1, miss1};
      for (int r = 0; r < 2; r++) begin
         chk($sformatf("level%0d", r), 32'(got[r][2]), 32'(cyc <= we[r]));
         chk($sformatf("busy%0d", r),  32'(got[r][1]), 32'((cyc <= bu[r]) || pd[r]));
         chk($sformatf("miss%0d", r),  32'(got[r][0]), 32'(me[r]));
         if (cyc < 64) begin
            h_lvl[r][cyc]  = got[r][2];
            h_busy[r][cyc] = got[r][1];
            h_miss[r][cyc] = got[r][0];
         end
      end
   endtask

   // One clock cycle: tick is held during cycle cyc, outputs checked in cyc+1.
   task automatic step(input bit tk);
      tick = tk;
      @(posedge clk);
      model_step(0, tk, cyc);
      model_step(1, tk, cyc);
      cyc++;
      #1;
      check_outputs();
   endtask

   // Asynchronous reset raised mid-cycle; outputs must clear before any edge.
   task automatic do_reset();
      tick  = 1'b0;
      reset = 1'b1;
      #2;
      chk("rst_level0", 32'(level0), 32'd0);
      chk("rst_level1", 32'(level1), 32'd0);
      chk("rst_busy0",  32'(busy0),  32'd0);
      chk("rst_busy1",  32'(busy1),  32'd0);
      chk("rst_miss0",  32'(miss0),  32'd0);
      chk("rst_miss1",  32'(miss1),  32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      cyc = 0;
   endtask

   task automatic scenario(input int t0, input int t1, input int t2);
      do_reset();
      for (int i = 0; i < 30; i++)
         step((i == t0) || (i == t1) || (i == t2));
   endtask

   int dens;

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Single tick: window 11-14, busy through 16.
      scenario(10, -1, -1);
      chk("t1_lvl10", 32'(h_lvl[0][10]), 32'd0);
      chk("t1_lvl11", 32'(h_lvl[0][11]), 32'd1);
      chk("t1_lvl14", 32'(h_lvl[0][14]), 32'd1);
      chk("t1_lvl15", 32'(h_lvl[0][15]), 32'd0);
      chk("t1_busy16", 32'(h_busy[0][16]), 32'd1);
      chk("t1_busy17", 32'(h_busy[0][17]), 32'd0);

      // Buffered second tick: second window 17-20 after a 2-cycle gap.
      scenario(10, 12, -1);
      chk("t2_lvl16", 32'(h_lvl[0][16]), 32'd0);
      chk("t2_lvl17", 32'(h_lvl[0][17]), 32'd1);
      chk("t2_lvl20", 32'(h_lvl[0][20]), 32'd1);
      chk("t2_lvl21", 32'(h_lvl[0][21]), 32'd0);

      // Third tick dropped: miss only in cycle 14.
      scenario(10, 12, 13);
      chk("t3_miss13", 32'(h_miss[0][13]), 32'd0);
      chk("t3_miss14", 32'(h_miss[0][14]), 32'd1);
      chk("t3_miss15", 32'(h_miss[0][15]), 32'd0);
      chk("t3_lvl17",  32'(h_lvl[0][17]),  32'd1);

      // Retrigger on instance 1: high 11-17, gap 18-19, idle at 20.
      scenario(10, 13, -1);
      chk("t4_lvl17",  32'(h_lvl[1][17]),  32'd1);
      chk("t4_lvl18",  32'(h_lvl[1][18]),  32'd0);
      chk("t4_busy19", 32'(h_busy[1][19]), 32'd1);
      chk("t4_busy20", 32'(h_busy[1][20]), 32'd0);

      // Tick in the last gap cycle starts the next window directly.
      scenario(10, 16, -1);
      chk("t5_lvl17",  32'(h_lvl[0][17]),  32'd1);
      chk("t5_lvl20",  32'(h_lvl[0][20]),  32'd1);
      chk("t5_lvl21",  32'(h_lvl[0][21]),  32'd0);
      chk("t5_busy23", 32'(h_busy[0][23]), 32'd0);

      // Reset in the middle of a window, then a fresh tick.
      do_reset();
      for (int i = 0; i < 12; i++) step(i == 10);
      chk("t6_lvl_pre", 32'(level0), 32'd1);
      do_reset();
      for (int i = 0; i < 12; i++) step(i == 5);
      chk("t6_lvl6", 32'(h_lvl[0][6]), 32'd1);
      chk("t6_lvl9", 32'(h_lvl[0][9]), 32'd1);
      chk("t6_lvl10", 32'(h_lvl[0][10]), 32'd0);

      // Randomized tick stream of varying density with occasional resets.
      do_reset();
      dens = 20;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) dens = $urandom_range(5, 90);
         if ($urandom_range(0, 599) == 0) do_reset();
         step($urandom_range(0, 99) < dens);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
